// File: rtl/ram_bank_np.sv
// ---------------------------------------------------------------------------
// RamBankNp : small register-file style RAM bank with a background clear sweep
//
// Purpose
//   N words of D bits.  Normal operation is a single-port write with a
//   zero-latency combinational read at the same address.  A one-cycle pulse
//   on i_clear starts a sweep that zeroes one word per clock, word 0 first,
//   and takes exactly N cycles.  o_busy is high for the whole sweep.
//
// Ports
//   i_clk    : clock, all state changes on the rising edge
//   i_rst_n  : asynchronous active-low reset (clears every word, FSM idle)
//   i_in     : write data, D bits
//   i_load   : write enable for word[i_addr]
//   i_addr   : word address shared by read and write, $clog2(N) bits
//   i_clear  : single-cycle request to start a clear sweep
//   o_out    : combinational read of word[i_addr]
//   o_busy   : registered flag, high while the sweep is running
// ---------------------------------------------------------------------------
module ram_bank_np #(
  parameter int N = 8,
  parameter int D = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [D-1:0]         i_in,
  input  logic                 i_load,
  input  logic [$clog2(N)-1:0] i_addr,
  input  logic                 i_clear,
  output logic [D-1:0]         o_out,
  output logic                 o_busy
);

  localparam int AW = $clog2(N);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [AW-1:0]  cnt;
  logic [AW-1:0]  cnt_next;
  logic           busy_q;
  logic [D-1:0]   word [N];
  logic [N-1:0]   load_en;
  logic [N-1:0]   clr_en;
  logic           write_ok;

  // A write is only accepted when idle and no clear is being requested on the
  // same edge, so a simultaneous clear always wins and the sweep is never
  // disturbed by partial writes.
  assign write_ok = (state == IDLE) && !i_clear;

  // One-hot address decode, gated by i_load, gives the per-word load enable.
  // The sweep uses a second decode driven by cnt.
  always_comb begin
    load_en = '0;
    clr_en  = '0;
    for (int i = 0; i < N; i++) begin
      load_en[i] = write_ok && i_load && (i_addr == AW'(i));
      clr_en[i]  = (state == CLEAR) && (cnt == AW'(i));
    end
  end

  // Next-state logic.  i_clear is only looked at in IDLE, so a request during
  // a sweep neither restarts nor stretches it.  cnt wraps back to 0 on the
  // final edge and therefore never exceeds N-1.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (i_clear) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      CLEAR: begin
        if (cnt == AW'(N - 1)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + AW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State register.  o_busy comes from its own flop loaded with the decoded
  // next state so the output is a clean register, not a decode of state bits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      busy_q <= (state_next == CLEAR);
    end
  end

  // Word storage.  Reset zeroes every word immediately, which also aborts a
  // sweep in progress.  The sweep and the write path never enable the same
  // word on the same edge because write_ok is false during CLEAR.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N; i++) begin
        word[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (clr_en[i]) begin
          word[i] <= '0;
        end else if (load_en[i]) begin
          word[i] <= i_in;
        end
      end
    end
  end

  assign o_out  = word[i_addr];
  assign o_busy = busy_q;

endmodule

// File: tb/tb_ram_bank_np.sv
// ---------------------------------------------------------------------------
// tb_ram_bank_np : self-checking bench for ram_bank_np (N=8, D=16)
//
// A directed table of write/read vectors, hand-written sequences for the
// read-during-write, sweep, priority, async-reset and isolation cases, then
// random traffic compared against a simple array model of the bank.
// ---------------------------------------------------------------------------
module tb_ram_bank_np;

  localparam int N = 8;
  localparam int D = 16;

  logic          clk;
  logic          rstN;
  logic [D-1:0]  dataIn;
  logic          load;
  logic [2:0]    addr;
  logic          clear;
  logic [D-1:0]  dataOut;
  logic          busy;

  int total;
  int bad;

  // Reference model: the bank contents, whether a sweep is running and which
  // word the sweep will zero on the next edge.
  logic [D-1:0]  modelMem [N];
  logic          modelBusy;
  int            modelPos;

  typedef struct {
    logic         ld;
    logic         cl;
    logic [2:0]   ad;
    logic [D-1:0] din;
    logic [D-1:0] expOut;
    logic         expBusy;
  } vec_t;

  vec_t vecs [10];

  ram_bank_np #(.N(N), .D(D)) dut (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .i_in    (dataIn),
    .i_load  (load),
    .i_addr  (addr),
    .i_clear (clear),
    .o_out   (dataOut),
    .o_busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value and count it.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < N; k++) modelMem[k] = '0;
    modelBusy = 1'b0;
    modelPos  = 0;
  endtask

  // One rising edge of the reference behaviour.
  task automatic modelStep(input logic ld, input logic cl, input logic [2:0] ad,
                           input logic [D-1:0] din);
    if (modelBusy) begin
      modelMem[modelPos] = '0;
      modelPos++;
      if (modelPos == N) begin
        modelBusy = 1'b0;
        modelPos  = 0;
      end
    end else if (cl) begin
      modelBusy = 1'b1;
      modelPos  = 0;
    end else if (ld) begin
      modelMem[ad] = din;
    end
  endtask

  // Drive inputs on the falling edge, let one rising edge happen, and return
  // 1 time unit after it with the model already advanced.
  task automatic applyStimulus(input logic ld, input logic cl, input logic [2:0] ad,
                               input logic [D-1:0] din);
    @(negedge clk);
    load   = ld;
    clear  = cl;
    addr   = ad;
    dataIn = din;
    @(posedge clk);
    modelStep(ld, cl, ad, din);
    #1;
  endtask

  // Read every address without a clock edge and compare with the model.
  task automatic checkAllWords(input string name);
    @(negedge clk);
    load  = 1'b0;
    clear = 1'b0;
    for (int k = 0; k < N; k++) begin
      addr = 3'(k);
      #1;
      checkOutput(name, 32'(dataOut), 32'(modelMem[k]));
    end
  endtask

  initial begin
    int busyCycles;
    logic          rl;
    logic          rc;
    logic [2:0]    ra;
    logic [D-1:0]  rd;

    total  = 0;
    bad    = 0;
    load   = 1'b0;
    clear  = 1'b0;
    addr   = '0;
    dataIn = '0;
    modelReset();

    // Reset state
    rstN = 1'b0;
    #12;
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_out", 32'(dataOut), 32'h0);
    @(negedge clk);
    rstN = 1'b1;

    // Directed write/read table
    vecs[0] = '{1'b1, 1'b0, 3'd3, 16'h1234, 16'h1234, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 3'd7, 16'hBEEF, 16'hBEEF, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 3'd0, 16'hFFFF, 16'h0000, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 3'd3, 16'h0000, 16'h1234, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 3'd7, 16'h0000, 16'hBEEF, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 3'd5, 16'h4321, 16'h0000, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 3'd1, 16'h4321, 16'h0000, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 3'd2, 16'h00AA, 16'h00AA, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 3'd3, 16'h9999, 16'h1234, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 3'd2, 16'h0000, 16'h00AA, 1'b0};
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].ld, vecs[i].cl, vecs[i].ad, vecs[i].din);
      checkOutput($sformatf("vec%0d_out", i), 32'(dataOut), 32'(vecs[i].expOut));
      checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].expBusy));
    end
    checkAllWords("table_all");

    // Read-during-write at addr 2
    @(negedge clk);
    addr   = 3'd2;
    dataIn = 16'h5555;
    load   = 1'b1;
    clear  = 1'b0;
    #1;
    checkOutput("rdw_before", 32'(dataOut), 32'h00AA);
    @(posedge clk);
    modelStep(1'b1, 1'b0, 3'd2, 16'h5555);
    #1;
    checkOutput("rdw_after", 32'(dataOut), 32'h5555);

    // Clear sweep: fill, pulse clear, watch each word fall in order
    for (int k = 0; k < N; k++) applyStimulus(1'b1, 1'b0, 3'(k), 16'hFFFF);
    applyStimulus(1'b0, 1'b1, 3'd0, 16'h0);
    checkOutput("sweep_start_busy", 32'(busy), 32'h1);
    busyCycles = 1;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      clear = 1'b0;
      addr  = 3'(k);
      #1;
      checkOutput($sformatf("sweep_w%0d_before", k), 32'(dataOut), 32'hFFFF);
      @(posedge clk);
      modelStep(1'b0, 1'b0, 3'(k), 16'h0);
      #1;
      checkOutput($sformatf("sweep_w%0d_after", k), 32'(dataOut), 32'h0);
      if (busy) busyCycles++;
    end
    checkOutput("sweep_busy_cycles", 32'(busyCycles), 32'd8);
    checkOutput("sweep_busy_end", 32'(busy), 32'h0);
    checkAllWords("sweep_all");

    // Priority: clear beats load, and requests during the sweep are ignored
    for (int k = 0; k < N; k++) applyStimulus(1'b1, 1'b0, 3'(k), 16'h3C3C);
    applyStimulus(1'b1, 1'b1, 3'd5, 16'h7777);
    checkOutput("prio_busy", 32'(busy), 32'h1);
    checkOutput("prio_no_write", 32'(dataOut), 32'h3C3C);
    busyCycles = 1;
    for (int c = 0; c < 20 && busy; c++) begin
      applyStimulus(1'b1, 1'b1, 3'd5, 16'h1234);
      if (busy) busyCycles++;
    end
    checkOutput("prio_busy_cycles", 32'(busyCycles), 32'd8);
    checkOutput("prio_busy_end", 32'(busy), 32'h0);
    checkAllWords("prio_all");

    // Async reset in the middle of a sweep
    for (int k = 0; k < N; k++) applyStimulus(1'b1, 1'b0, 3'(k), 16'hA5A5);
    applyStimulus(1'b0, 1'b1, 3'd7, 16'h0);
    for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b0, 3'd7, 16'h0);
    checkOutput("arst_pre_busy", 32'(busy), 32'h1);
    checkOutput("arst_pre_out", 32'(dataOut), 32'hA5A5);
    #2;
    rstN = 1'b0;
    #1;
    modelReset();
    checkOutput("arst_busy", 32'(busy), 32'h0);
    checkOutput("arst_out", 32'(dataOut), 32'h0);
    @(negedge clk);
    rstN = 1'b1;
    checkAllWords("arst_all");
    applyStimulus(1'b1, 1'b0, 3'd4, 16'h4444);
    checkOutput("post_reset_write", 32'(dataOut), 32'h4444);

    // Isolation: distinct values, then rewrite only addr 0
    for (int k = 0; k < N; k++) applyStimulus(1'b1, 1'b0, 3'(k), 16'(16'h1000 + k));
    applyStimulus(1'b1, 1'b0, 3'd0, 16'hABCD);
    checkOutput("iso_w0", 32'(dataOut), 32'hABCD);
    @(negedge clk);
    load = 1'b0;
    for (int k = 1; k < N; k++) begin
      addr = 3'(k);
      #1;
      checkOutput($sformatf("iso_w%0d", k), 32'(dataOut), 32'(16'h1000 + k));
    end

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rl = ($urandom_range(0, 1) == 1);
      rc = ($urandom_range(0, 19) == 0);
      ra = 3'($urandom_range(0, N - 1));
      rd = 16'($urandom);
      @(negedge clk);
      load   = rl;
      clear  = rc;
      addr   = ra;
      dataIn = rd;
      #1;
      checkOutput("rand_pre_out", 32'(dataOut), 32'(modelMem[ra]));
      @(posedge clk);
      modelStep(rl, rc, ra, rd);
      #1;
      checkOutput("rand_out", 32'(dataOut), 32'(modelMem[ra]));
      checkOutput("rand_busy", 32'(busy), 32'(modelBusy));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/ram_bank_np.md
RAM_BANK_NP -- requirements
Module: ram_bank_np

Interface
REQ-001 Parameter N, default 8, number of words; SHALL be a power of two, at least 2.
REQ-002 Parameter D, default 16, bit width of each word.
REQ-003 Port i_clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 Port i_rst_n, input, 1 bit: reset; asynchronous, active-low.
REQ-005 Port i_in, input, D bits: write data.
REQ-006 Port i_load, input, 1 bit: write enable for the addressed word.
REQ-007 Port i_addr, input, $clog2(N) bits: word address, shared by read and write.
REQ-008 Port i_clear, input, 1 bit: single-cycle request to start a full-bank clear sweep.
REQ-009 Port o_out, output, D bits: contents of word[i_addr].
REQ-010 Port o_busy, output, 1 bit: high while a clear sweep is in progress.

Function
REQ-011 Storage SHALL be N registers of D bits, word[0..N-1].
REQ-012 Write-enable routing: i_addr SHALL be one-hot decoded to N lines, each gated by i_load (load demultiplex), yielding a per-word enable.
REQ-013 Write: rising edge with i_load=1, FSM in IDLE, i_clear=0 SHALL set word[i_addr] to i_in; all other words are unchanged.
REQ-014 Read: o_out SHALL be combinational word[i_addr], with zero read latency.
REQ-015 Read-during-write: o_out SHALL show the old value before the edge and i_in from the edge onward.
REQ-016 FSM states SHALL be IDLE and CLEAR; the clear counter cnt SHALL be $clog2(N) bits wide.
REQ-017 IDLE to CLEAR: i_clear=1 at a rising edge SHALL set cnt=0 and enter CLEAR.
REQ-018 In CLEAR, each rising edge SHALL write zero to word[cnt] and increment cnt.
REQ-019 CLEAR to IDLE: on the edge where cnt==N-1, word[N-1] SHALL be zeroed and the FSM SHALL return to IDLE with cnt=0.
REQ-020 Sweep timing: the sweep SHALL take exactly N cycles, and o_busy=1 exactly when the state is CLEAR.
REQ-021 o_busy SHALL be a registered, glitch-free output.
REQ-022 If i_clear and i_load are both high in IDLE, the clear SHALL win and the write SHALL be dropped.
REQ-023 i_load SHALL be ignored while in CLEAR, and no partial writes SHALL occur.
REQ-024 i_clear SHALL be ignored while in CLEAR; no restart and no extension of the sweep.
REQ-025 o_out SHALL remain a valid combinational read during CLEAR; already-cleared words read 0.
REQ-026 cnt SHALL never exceed N-1, and i_addr values SHALL be used without bounds checks.

Reset
REQ-027 With i_rst_n=0, asynchronously and independent of i_clk: all words SHALL be 0, state IDLE, cnt 0, o_busy 0.
REQ-028 As a consequence of REQ-027, o_out SHALL be 0 during reset.
REQ-029 Reset asserted mid-sweep SHALL abort the sweep immediately, and all words SHALL read 0 after reset.
REQ-030 After i_rst_n deasserts, the first rising edge SHALL process i_load and i_clear normally.

Verification (N=8, D=16)
REQ-031 Write/read: reset; write 0x1234 to addr 3 and 0xBEEF to addr 7 -> o_out reads 0x1234 at addr 3, 0xBEEF at addr 7, 0x0000 at every other address.
REQ-032 Read-during-write: addr 2 holds 0x00AA; drive i_in=0x5555, i_load=1 -> o_out=0x00AA before the edge and 0x5555 after it.
REQ-033 Clear sweep: fill all 8 words with 0xFFFF; pulse i_clear -> o_busy high for exactly 8 cycles; word k reads 0 from cycle k+1; all words 0 once o_busy falls.
REQ-034 Priority: in IDLE assert i_clear and i_load (addr 5, 0x7777) together -> the sweep starts and word 5 ends at 0; i_load=1 and i_clear=1 during the sweep -> no write, sweep still ends after 8 cycles.
REQ-035 Async reset mid-sweep: fill with 0xA5A5, start a clear, pull i_rst_n low at sweep cycle 3 between edges -> o_busy=0 and o_out=0 without a clock edge; all 8 words read 0.
REQ-036 Isolation: write each address with a distinct value (0x1000+k), rewrite addr 0 -> only word 0 changes, others keep 0x1000+k.
